dec_timer: RTL and testbench

Loadable down-counting timer built on the library's prefix-lookahead arithmetic: a new decrementer (the borrow counterpart of the carry incrementer) computes the next count and its borrow-out. The borrow-out is the terminal-count detect, so no separate zero comparator exists. It sits beside the incrementer-based counters as the timeout/period generator. Expiry events leave through a one-entry valid/ready buffer with sticky overrun reporting.

---
 rtl/lau_pkg.sv | 16 +
 rtl/DecC.sv | 28 ++
 rtl/PrefixAnd.sv | 45 ++++
 rtl/behavioural_DecC.sv | 13 +
 rtl/dec_timer.sv | 114 +++++++++++
 tb/tb_dec_timer.sv | 247 ++++++++++++++++++++++++
 6 files changed

// File: rtl/lau_pkg.sv
// Shared types for the lookahead arithmetic library: prefix-structure speed
// selection and the timer state encoding.
package lau_pkg;

  typedef enum logic [1:0] {
    SLOW,
    MEDIUM,
    FAST
  } speed_e;

  typedef enum logic {
    IDLE,
    RUN
  } tmr_state_e;

endpackage

// File: rtl/DecC.sv
// Lookahead decrementer: {BO, Z} = A - BI. A bit toggles when every lower
// bit is zero and the borrow-in is set, which is a prefix AND of {~A, BI}.
module DecC
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] A,
  input  logic             BI,
  output logic [width-1:0] Z,
  output logic             BO
);

  logic [width:0] prefixOut;

  PrefixAnd #(
    .n    (width + 1),
    .speed(speed)
  ) u_prefix (
    .PI({~A, BI}),
    .PO(prefixOut)
  );

  assign Z  = A ^ prefixOut[width-1:0];
  assign BO = prefixOut[width];

endmodule

// File: rtl/PrefixAnd.sv
// Prefix AND over n inputs: PO[k] = &PI[k:0]. SLOW is a ripple chain,
// MEDIUM a Sklansky tree, FAST a Kogge-Stone tree.
module PrefixAnd
  import lau_pkg::*;
#(
  parameter int     n     = 9,
  parameter speed_e speed = FAST
) (
  input  logic [n-1:0] PI,
  output logic [n-1:0] PO
);

  if (speed == SLOW) begin : g_slow
    for (genvar i = 0; i < n; i++) begin : g_rip
      logic r;
      if (i == 0) begin : g_first
        assign r = PI[0];
      end else begin : g_next
        assign r = g_rip[i-1].r & PI[i];
      end
      assign PO[i] = r;
    end
  end else begin : g_tree
    localparam int Levels = $clog2(n);
    // Each level doubles the span of every partial product.
    for (genvar s = 0; s <= Levels; s++) begin : g_lvl
      logic [n-1:0] v;
      if (s == 0) begin : g_in
        assign v = PI;
      end else begin : g_step
        for (genvar i = 0; i < n; i++) begin : g_bit
          if (speed == FAST && i >= (1 << (s - 1))) begin : g_ks
            assign v[i] = g_lvl[s-1].v[i] & g_lvl[s-1].v[i-(1<<(s-1))];
          end else if (speed != FAST && ((i >> (s - 1)) & 1) == 1) begin : g_sk
            assign v[i] = g_lvl[s-1].v[i] & g_lvl[s-1].v[((i>>(s-1))<<(s-1))-1];
          end else begin : g_pass
            assign v[i] = g_lvl[s-1].v[i];
          end
        end
      end
    end
    assign PO = g_lvl[Levels].v;
  end

endmodule

// File: rtl/behavioural_DecC.sv
// Arithmetic reference for DecC, used for equivalence checking.
module behavioural_DecC #(
  parameter int width = 8
) (
  input  logic [width-1:0] A,
  input  logic             BI,
  output logic [width-1:0] Z,
  output logic             BO
);

  assign {BO, Z} = {1'b0, A} - {{width{1'b0}}, BI};

endmodule

// File: rtl/dec_timer.sv
// Loadable down-counting timer; the decrementer's borrow-out doubles as the
// terminal-count detect. Expiries leave through a one-entry event buffer.
module dec_timer
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [width-1:0] load_value_i,
  input  logic             load_periodic_i,
  input  logic             en_i,
  input  logic             stop_i,
  output logic [width-1:0] count_o,
  output logic             busy_o,
  output logic             exp_valid_o,
  input  logic             exp_ready_i,
  output logic             overrun_o
);

  tmr_state_e       state_q, state_d;
  logic [width-1:0] count_q, count_d;
  logic [width-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             expValid_q, expValid_d;
  logic             overrun_q, overrun_d;

  logic [width-1:0] decZ;
  logic             decBo;
  logic             loadFire;
  logic             expiry;

  DecC #(
    .width(width),
    .speed(speed)
  ) u_dec (
    .A (count_q),
    .BI(1'b1),
    .Z (decZ),
    .BO(decBo)
  );

  assign load_ready_o = ~expValid_q;
  assign loadFire     = load_valid_i & load_ready_o;

  // Counter control: stop beats load beats decrement; a borrow means the
  // count was already zero, so that cycle is the expiry.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    expValid_d = expValid_q;
    overrun_d  = overrun_q;
    expiry     = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
      count_d = '0;
    end else if (loadFire) begin
      state_d    = RUN;
      count_d    = load_value_i;
      reload_d   = load_value_i;
      periodic_d = load_periodic_i;
      overrun_d  = 1'b0;
    end else if (state_q == RUN && en_i) begin
      if (!decBo) begin
        count_d = decZ;
      end else begin
        expiry = 1'b1;
        if (periodic_q) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end
    end

    // A new expiry into a full buffer is lost unless the old one leaves now.
    if (expiry) begin
      if (!expValid_q)        expValid_d = 1'b1;
      else if (!exp_ready_i)  overrun_d  = 1'b1;
    end else if (expValid_q && exp_ready_i) begin
      expValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      expValid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      expValid_q <= expValid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign count_o     = count_q;
  assign busy_o      = (state_q == RUN);
  assign exp_valid_o = expValid_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_dec_timer.sv
// Self-checking bench for dec_timer and the DecC decrementer.
module tb_dec_timer;
  import lau_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN, loadValid, loadPeriodic, en, stop, expReady;
  logic [7:0] loadValue;
  logic       loadReady, busy, expValid, overrun;
  logic [7:0] count;

  dec_timer #(.width(8), .speed(FAST)) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .load_valid_i   (loadValid),
    .load_ready_o   (loadReady),
    .load_value_i   (loadValue),
    .load_periodic_i(loadPeriodic),
    .en_i           (en),
    .stop_i         (stop),
    .count_o        (count),
    .busy_o         (busy),
    .exp_valid_o    (expValid),
    .exp_ready_i    (expReady),
    .overrun_o      (overrun)
  );

  // Standalone decrementers at other widths and speeds
  logic        dBi;
  logic [0:0]  d1A, d1Z;
  logic [4:0]  d5A, d5Z;
  logic [7:0]  d8A, d8Z;
  logic [15:0] d16A, d16Z;
  logic        d1Bo, d5Bo, d8Bo, d16Bo;

  DecC #(.width(1),  .speed(FAST))   u_d1  (.A(d1A),  .BI(dBi), .Z(d1Z),  .BO(d1Bo));
  DecC #(.width(5),  .speed(SLOW))   u_d5  (.A(d5A),  .BI(dBi), .Z(d5Z),  .BO(d5Bo));
  DecC #(.width(8),  .speed(MEDIUM)) u_d8  (.A(d8A),  .BI(dBi), .Z(d8Z),  .BO(d8Bo));
  DecC #(.width(16), .speed(SLOW))   u_d16 (.A(d16A), .BI(dBi), .Z(d16Z), .BO(d16Bo));

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic       mRun, mPer, mValid, mOvr;
  logic [7:0] mCount, mReload;

  typedef struct {
    logic       rstN, lv;
    logic [7:0] val;
    logic       per, en, stop, er;
    logic [7:0] wCount;
    logic       wBusy, wValid, wOvr;
  } vec_t;

  vec_t vecs[10];

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string name);
    checks++;
    if ({count, busy, expValid, loadReady, overrun} !== {mCount, mRun, mValid, ~mValid, mOvr}) begin
      failures++;
      $display("[TB] FAIL %s: count=%0d busy=%b valid=%b ready=%b ovr=%b, want count=%0d busy=%b valid=%b ready=%b ovr=%b",
               name, count, busy, expValid, loadReady, overrun, mCount, mRun, mValid, ~mValid, mOvr);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic lv, input logic [7:0] val,
                               input logic per, input logic e, input logic st, input logic er);
    rstN = r; loadValid = lv; loadValue = val; loadPeriodic = per;
    en = e; stop = st; expReady = er;
  endtask

  // Behaviour of one clock edge from the timer's rules, evaluated on the
  // inputs currently applied.
  task automatic modelStep();
    logic expiryNow;
    logic accept;
    expiryNow = 1'b0;
    accept = loadValid && !mValid;
    if (!rstN) begin
      mRun = 0; mPer = 0; mValid = 0; mOvr = 0; mCount = 0; mReload = 0;
    end else begin
      if (stop) begin
        mRun = 0; mCount = 0;
      end else if (accept) begin
        mRun = 1; mCount = loadValue; mReload = loadValue; mPer = loadPeriodic; mOvr = 0;
      end else if (mRun && en) begin
        if (mCount == 0) begin
          expiryNow = 1'b1;
          if (mPer) mCount = mReload;
          else mRun = 0;
        end else begin
          mCount = mCount - 8'd1;
        end
      end
      if (expiryNow) begin
        if (mValid && !expReady) mOvr = 1;
        mValid = 1;
      end else if (mValid && expReady) begin
        mValid = 0;
      end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int enCount;
    int pseq[9];
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    {mRun, mPer, mValid, mOvr, mCount, mReload} = '0;

    // Decrementer equivalence against plain subtraction
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 2; b++) begin
        logic [8:0] w8;
        logic [5:0] w5;
        logic [1:0] w1;
        dBi = b[0]; d8A = a[7:0]; d5A = a[4:0]; d1A = a[0:0];
        #1;
        w8 = {1'b0, d8A} - {8'd0, dBi};
        checkVal("dec8", {23'd0, d8Bo, d8Z}, {23'd0, w8});
        if (a < 32) begin
          w5 = {1'b0, d5A} - {5'd0, dBi};
          checkVal("dec5", {26'd0, d5Bo, d5Z}, {26'd0, w5});
        end
        if (a < 2) begin
          w1 = {1'b0, d1A} - {1'b0, dBi};
          checkVal("dec1", {30'd0, d1Bo, d1Z}, {30'd0, w1});
        end
      end
    end
    for (int k = 0; k < 200; k++) begin
      logic [16:0] w16;
      d16A = (k < 4) ? 16'(k) : 16'($urandom);
      dBi = $urandom_range(0, 1);
      #1;
      w16 = {1'b0, d16A} - {16'd0, dBi};
      checkVal("dec16", {15'd0, d16Bo, d16Z}, {15'd0, w16});
    end

    // Table: reset, one-shot N=3, blocked loads, pop, stop beating load
    vecs[0] = '{0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0};
    vecs[1] = '{1, 1, 8'd3, 0, 1, 0, 0, 8'd3, 1, 0, 0};
    vecs[2] = '{1, 0, 8'd0, 0, 1, 0, 0, 8'd2, 1, 0, 0};
    vecs[3] = '{1, 0, 8'd0, 0, 1, 0, 0, 8'd1, 1, 0, 0};
    vecs[4] = '{1, 0, 8'd0, 0, 1, 0, 0, 8'd0, 1, 0, 0};
    vecs[5] = '{1, 0, 8'd0, 0, 1, 0, 0, 8'd0, 0, 1, 0};
    vecs[6] = '{1, 1, 8'd5, 0, 1, 0, 0, 8'd0, 0, 1, 0};
    vecs[7] = '{1, 1, 8'd5, 0, 1, 0, 1, 8'd0, 0, 0, 0};
    vecs[8] = '{1, 1, 8'd5, 0, 0, 0, 0, 8'd5, 1, 0, 0};
    vecs[9] = '{1, 1, 8'd7, 1, 1, 1, 0, 8'd0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].lv, vecs[i].val, vecs[i].per,
                    vecs[i].en, vecs[i].stop, vecs[i].er);
      tick();
      checkVal($sformatf("vec%0d", i), {20'd0, count, busy, expValid, loadReady, overrun},
               {20'd0, vecs[i].wCount, vecs[i].wBusy, vecs[i].wValid, ~vecs[i].wValid, vecs[i].wOvr});
      checkOutput($sformatf("vecModel%0d", i));
    end

    // Periodic N=2 with the consumer always ready
    pseq = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
    applyStimulus(1, 1, 8'd2, 1, 1, 0, 1);
    tick();
    checkOutput("per2Load");
    applyStimulus(1, 0, 8'd0, 0, 1, 0, 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      checkVal("per2Count", {24'd0, count}, pseq[i]);
      checkVal("per2Valid", {31'd0, expValid}, {31'd0, (pseq[i] == 2)});
      checkVal("per2Ovr", {31'd0, overrun}, 0);
      checkOutput("per2Model");
    end

    // Periodic N=0 with the consumer stalled: overrun from the second expiry
    applyStimulus(1, 0, 8'd0, 0, 0, 0, 1);
    tick();
    applyStimulus(1, 1, 8'd0, 1, 1, 0, 0);
    tick();
    checkOutput("per0Load");
    applyStimulus(1, 0, 8'd0, 0, 1, 0, 0);
    tick();
    checkVal("per0FirstExp", {30'd0, expValid, overrun}, 32'b10);
    tick();
    checkVal("per0SecondExp", {30'd0, expValid, overrun}, 32'b11);
    tick();
    checkOutput("per0Third");
    applyStimulus(1, 0, 8'd0, 0, 0, 0, 1);
    tick();
    checkVal("per0PopKeepsOvr", {30'd0, expValid, overrun}, 32'b01);
    applyStimulus(1, 1, 8'd0, 1, 1, 0, 0);
    tick();
    checkVal("reloadClearsOvr", {31'd0, overrun}, 0);
    applyStimulus(1, 0, 8'd0, 0, 1, 0, 0);
    tick();
    checkOutput("per0Again");
    applyStimulus(1, 0, 8'd0, 0, 1, 0, 1);
    tick();
    checkVal("expiryWithPop", {30'd0, expValid, overrun}, 32'b10);
    checkOutput("expiryWithPopModel");

    // Long count with gaps in the enable, then reset mid-count
    applyStimulus(1, 0, 8'd0, 0, 0, 0, 1);
    tick();
    applyStimulus(1, 1, 8'hFF, $urandom_range(0, 1), 0, 0, 0);
    tick();
    checkOutput("gapLoad");
    enCount = 0;
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1, 0, 8'd0, 0, $urandom_range(0, 1), 0, $urandom_range(0, 1));
      if (en) enCount++;
      tick();
      checkOutput("gapModel");
    end
    checkVal("gapCount", {24'd0, count}, 255 - enCount);
    applyStimulus(0, 0, 8'd0, 0, 1, 0, 0);
    tick();
    checkVal("midReset", {20'd0, count, busy, expValid, loadReady, overrun}, 32'b0010);

    // Fully random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 1), 8'($urandom_range(0, 6)),
                    $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 1));
      tick();
      checkOutput("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
